// File: rtl/maze_mover.sv
// Tile-maze player movement controller: runtime-loadable wall bitmap, move
// validation FSM with auto-repeat cooldown, registered pixel bounding box.
module maze_mover #(
    parameter int COLS        = 20,
    parameter int ROWS        = 16,
    parameter int TILE_W      = 32,
    parameter int TILE_H      = 30,
    parameter int START_COL   = 0,
    parameter int START_ROW   = 0,
    parameter int GOAL_COL    = 19,
    parameter int GOAL_ROW    = 15,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      left,
    input  logic                      up,
    input  logic                      down,
    input  logic                      right,
    input  logic                      map_we,
    input  logic [$clog2(ROWS)-1:0]   map_row,
    input  logic [COLS-1:0]           map_data,
    output logic [$clog2(COLS)-1:0]   col,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [9:0]                xFlr,
    output logic [9:0]                xCeil,
    output logic [9:0]                yFlr,
    output logic [9:0]                yCeil,
    output logic                      moved,
    output logic                      wallblks,
    output logic                      busy,
    output logic                      win
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0] START_C  = CW'(START_COL);
    localparam logic [RW-1:0] START_R  = RW'(START_ROW);
    localparam logic [CW-1:0] GOAL_C   = CW'(GOAL_COL);
    localparam logic [RW-1:0] GOAL_R   = RW'(GOAL_ROW);
    localparam logic [CW-1:0] LAST_C   = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_R   = RW'(ROWS - 1);
    localparam logic [HW-1:0] HOLD_LD  = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
    localparam logic          START_WIN = (START_COL == GOAL_COL) && (START_ROW == GOAL_ROW);

    localparam logic [9:0] START_XF = 10'(START_COL * TILE_W);
    localparam logic [9:0] START_XC = 10'((START_COL + 1) * TILE_W);
    localparam logic [9:0] START_YF = 10'(START_ROW * TILE_H);
    localparam logic [9:0] START_YC = 10'((START_ROW + 1) * TILE_H);

    if (COLS * TILE_W > 1023) begin : g_bad_width
        $error("maze_mover: COLS*TILE_W exceeds 10-bit pixel range");
    end
    if (ROWS * TILE_H > 1023) begin : g_bad_height
        $error("maze_mover: ROWS*TILE_H exceeds 10-bit pixel range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMMIT,
        S_COOL
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [CW-1:0]  tgt_col_q;
    logic [RW-1:0]  tgt_row_q;
    logic           oob_q;
    logic           wall_q;
    logic [HW-1:0]  cnt_q;
    logic [9:0]     xflr_q;
    logic [9:0]     xceil_q;
    logic [9:0]     yflr_q;
    logic [9:0]     yceil_q;
    logic           moved_q;
    logic           wallblks_q;
    logic           busy_q;
    logic           win_q;
    logic [COLS-1:0] map_q [ROWS];

    logic           req_valid;
    logic [CW-1:0]  tgt_col_d;
    logic [RW-1:0]  tgt_row_d;
    logic           oob_d;

    function automatic logic [9:0] col_px(input logic [CW-1:0] c);
        return 10'(int'(c) * TILE_W);
    endfunction

    function automatic logic [9:0] row_px(input logic [RW-1:0] r);
        return 10'(int'(r) * TILE_H);
    endfunction

    assign req_valid = $onehot({left, up, down, right});

    // Target tile and edge check; only meaningful when req_valid is set.
    always_comb begin
        tgt_col_d = col_q;
        tgt_row_d = row_q;
        oob_d     = 1'b0;
        if (left) begin
            if (col_q == '0) oob_d = 1'b1;
            else             tgt_col_d = col_q - 1'b1;
        end else if (right) begin
            if (col_q == LAST_C) oob_d = 1'b1;
            else                 tgt_col_d = col_q + 1'b1;
        end else if (up) begin
            if (row_q == '0) oob_d = 1'b1;
            else             tgt_row_d = row_q - 1'b1;
        end else if (down) begin
            if (row_q == LAST_R) oob_d = 1'b1;
            else                 tgt_row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            col_q      <= START_C;
            row_q      <= START_R;
            tgt_col_q  <= START_C;
            tgt_row_q  <= START_R;
            oob_q      <= 1'b0;
            wall_q     <= 1'b0;
            cnt_q      <= '0;
            xflr_q     <= START_XF;
            xceil_q    <= START_XC;
            yflr_q     <= START_YF;
            yceil_q    <= START_YC;
            moved_q    <= 1'b0;
            wallblks_q <= 1'b0;
            busy_q     <= 1'b0;
            win_q      <= START_WIN;
        end else begin
            moved_q    <= 1'b0;
            wallblks_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !win_q) begin
                        tgt_col_q <= tgt_col_d;
                        tgt_row_q <= tgt_row_d;
                        oob_q     <= oob_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // Out-of-bounds targets may index past the map; skip the read.
                    if (!oob_q) wall_q <= map_q[tgt_row_q][tgt_col_q];
                    else        wall_q <= 1'b1;
                    state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (oob_q || wall_q) begin
                        wallblks_q <= 1'b1;
                    end else begin
                        col_q    <= tgt_col_q;
                        row_q    <= tgt_row_q;
                        xflr_q   <= col_px(tgt_col_q);
                        xceil_q  <= 10'(col_px(tgt_col_q) + 10'(TILE_W));
                        yflr_q   <= row_px(tgt_row_q);
                        yceil_q  <= 10'(row_px(tgt_row_q) + 10'(TILE_H));
                        moved_q  <= 1'b1;
                        if (tgt_col_q == GOAL_C && tgt_row_q == GOAL_R) win_q <= 1'b1;
                    end
                    if (HOLD_CYCLES > 0) begin
                        cnt_q   <= HOLD_LD;
                        state_q <= S_COOL;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_COOL: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Row writes land at the edge; a same-edge LOOKUP read sees the old row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < ROWS; r++) map_q[r] <= '0;
        end else if (map_we && (int'(map_row) < ROWS)) begin
            map_q[map_row] <= map_data;
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign xFlr     = xflr_q;
    assign xCeil    = xceil_q;
    assign yFlr     = yflr_q;
    assign yCeil    = yceil_q;
    assign moved    = moved_q;
    assign wallblks = wallblks_q;
    assign busy     = busy_q;
    assign win      = win_q;

endmodule

// File: tb/tb_maze_mover.sv
// Directed bench for maze_mover with default geometry and HOLD_CYCLES=4.
module tb_maze_mover;

    logic        clk;
    logic        reset_n;
    logic        left, up, down, right;
    logic        map_we;
    logic [3:0]  map_row;
    logic [19:0] map_data;
    logic [4:0]  col;
    logic [3:0]  row;
    logic [9:0]  xFlr, xCeil, yFlr, yCeil;
    logic        moved, wallblks, busy, win;

    int total = 0;
    int bad   = 0;

    maze_mover #(
        .COLS(20), .ROWS(16), .TILE_W(32), .TILE_H(30),
        .START_COL(0), .START_ROW(0), .GOAL_COL(19), .GOAL_ROW(15),
        .HOLD_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .left(left), .up(up), .down(down), .right(right),
        .map_we(map_we), .map_row(map_row), .map_data(map_data),
        .col(col), .row(row),
        .xFlr(xFlr), .xCeil(xCeil), .yFlr(yFlr), .yCeil(yCeil),
        .moved(moved), .wallblks(wallblks), .busy(busy), .win(win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {left, up, down, right} = 4'b0;
        map_we = 1'b0; map_row = '0; map_data = '0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic write_row(input logic [3:0] r, input logic [19:0] d);
        map_we = 1'b1; map_row = r; map_data = d;
        step(1);
        map_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (col !== 5'd0)    begin bad++; $display("FAIL reset_col got=%0d exp=0", col); end
        total++; if (row !== 4'd0)    begin bad++; $display("FAIL reset_row got=%0d exp=0", row); end
        total++; if (xFlr !== 10'd0)  begin bad++; $display("FAIL reset_xFlr got=%0d exp=0", xFlr); end
        total++; if (xCeil !== 10'd32) begin bad++; $display("FAIL reset_xCeil got=%0d exp=32", xCeil); end
        total++; if (yFlr !== 10'd0)  begin bad++; $display("FAIL reset_yFlr got=%0d exp=0", yFlr); end
        total++; if (yCeil !== 10'd30) begin bad++; $display("FAIL reset_yCeil got=%0d exp=30", yCeil); end
        total++; if ({busy, moved, wallblks, win} !== 4'b0)
            begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, moved, wallblks, win}); end
    endtask

    task automatic test_move_right();
        do_reset();
        right = 1'b1;
        step(1);
        right = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mv_busy_N got=%b exp=1", busy); end
        step(1);
        total++; if (col !== 5'd0 || moved !== 1'b0)
            begin bad++; $display("FAIL mv_N1 col=%0d moved=%b exp col=0 moved=0", col, moved); end
        step(1);
        total++; if (col !== 5'd1) begin bad++; $display("FAIL mv_col got=%0d exp=1", col); end
        total++; if (xFlr !== 10'd32 || xCeil !== 10'd64)
            begin bad++; $display("FAIL mv_px got=%0d/%0d exp=32/64", xFlr, xCeil); end
        total++; if (moved !== 1'b1 || wallblks !== 1'b0)
            begin bad++; $display("FAIL mv_pulse moved=%b wallblks=%b exp 1/0", moved, wallblks); end
        step(1);
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL mv_pulse_len got=%b exp=0", moved); end
        step(2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mv_busy_N5 got=%b exp=1", busy); end
        step(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mv_idle_N6 got=%b exp=0", busy); end
    endtask

    task automatic test_wall();
        do_reset();
        write_row(4'd0, 20'h00002);
        right = 1'b1; step(1); right = 1'b0;
        step(2);
        total++; if (wallblks !== 1'b1 || moved !== 1'b0 || col !== 5'd0)
            begin bad++; $display("FAIL wall_right wb=%b mv=%b col=%0d exp 1/0/0", wallblks, moved, col); end
        step(5);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wall_idle got=%b exp=0", busy); end
        left = 1'b1; step(1); left = 1'b0;
        step(2);
        total++; if (wallblks !== 1'b1 || moved !== 1'b0 || col !== 5'd0 || xFlr !== 10'd0)
            begin bad++; $display("FAIL wall_oob wb=%b mv=%b col=%0d x=%0d exp 1/0/0/0", wallblks, moved, col, xFlr); end
        step(5);
        // Wall written under the player, then a same-edge write during LOOKUP.
        write_row(4'd0, 20'h00001);
        total++; if (col !== 5'd0 || row !== 4'd0 || moved !== 1'b0)
            begin bad++; $display("FAIL wall_onplayer col=%0d row=%0d mv=%b exp 0/0/0", col, row, moved); end
        down = 1'b1; step(1); down = 1'b0;
        map_we = 1'b1; map_row = 4'd1; map_data = 20'h00001;
        step(1);
        map_we = 1'b0;
        step(1);
        total++; if (moved !== 1'b1 || row !== 4'd1 || yFlr !== 10'd30 || yCeil !== 10'd60)
            begin bad++; $display("FAIL wall_olddata mv=%b row=%0d y=%0d/%0d exp 1/1/30/60", moved, row, yFlr, yCeil); end
        step(5);
        up = 1'b1; step(1); up = 1'b0;
        step(2);
        total++; if (wallblks !== 1'b1 || row !== 4'd1)
            begin bad++; $display("FAIL wall_newrow wb=%b row=%0d exp 1/1", wallblks, row); end
        step(5);
    endtask

    task automatic test_invalid();
        int errs;
        do_reset();
        errs = 0;
        left = 1'b1; up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (busy || moved || wallblks) errs++;
        end
        left = 1'b0; up = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (busy || moved || wallblks) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL invalid_activity got=%0d exp=0", errs); end
        total++; if (col !== 5'd0 || row !== 4'd0)
            begin bad++; $display("FAIL invalid_pos col=%0d row=%0d exp 0/0", col, row); end
    endtask

    task automatic test_autorepeat();
        do_reset();
        down = 1'b1;
        step(3);
        total++; if (row !== 4'd1 || moved !== 1'b1)
            begin bad++; $display("FAIL rep_1 row=%0d mv=%b exp 1/1", row, moved); end
        step(6);
        total++; if (row !== 4'd1 || moved !== 1'b0)
            begin bad++; $display("FAIL rep_hold row=%0d mv=%b exp 1/0", row, moved); end
        step(1);
        total++; if (row !== 4'd2 || moved !== 1'b1)
            begin bad++; $display("FAIL rep_2 row=%0d mv=%b exp 2/1", row, moved); end
        step(7);
        total++; if (row !== 4'd3 || moved !== 1'b1 || yFlr !== 10'd90)
            begin bad++; $display("FAIL rep_3 row=%0d mv=%b y=%0d exp 3/1/90", row, moved, yFlr); end
        step(2);
        down = 1'b0;
        step(10);
        total++; if (row !== 4'd3 || busy !== 1'b0)
            begin bad++; $display("FAIL rep_release row=%0d busy=%b exp 3/0", row, busy); end
    endtask

    task automatic test_win();
        int errs;
        do_reset();
        right = 1'b1;
        for (int i = 0; i < 300 && col != 5'd19; i++) step(1);
        right = 1'b0;
        total++; if (col !== 5'd19 || xFlr !== 10'd608 || xCeil !== 10'd640)
            begin bad++; $display("FAIL win_walkcol col=%0d x=%0d/%0d exp 19/608/640", col, xFlr, xCeil); end
        step(6);
        down = 1'b1;
        errs = 0;
        for (int i = 0; i < 300 && row != 4'd15; i++) begin
            if (win) errs++;
            step(1);
        end
        down = 1'b0;
        total++; if (errs !== 0) begin bad++; $display("FAIL win_early got=%0d exp=0", errs); end
        total++; if (row !== 4'd15 || win !== 1'b1)
            begin bad++; $display("FAIL win_set row=%0d win=%b exp 15/1", row, win); end
        step(8);
        up = 1'b1;
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (busy || moved || wallblks || !win) errs++;
        end
        up = 1'b0;
        total++; if (errs !== 0 || row !== 4'd15 || col !== 5'd19)
            begin bad++; $display("FAIL win_locked errs=%0d pos=%0d,%0d exp 0 at 19,15", errs, col, row); end
    endtask

    task automatic test_reset_lookup();
        int errs;
        do_reset();
        total++; if (win !== 1'b0) begin bad++; $display("FAIL rst_win_clear got=%b exp=0", win); end
        right = 1'b1; step(1); right = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_in_lookup busy=%b exp=1", busy); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (col !== 5'd0 || busy !== 1'b0 || moved !== 1'b0 || win !== 1'b0 || xFlr !== 10'd0)
            begin bad++; $display("FAIL rst_abort col=%0d busy=%b mv=%b win=%b exp 0/0/0/0", col, busy, moved, win); end
        step(1);
        reset_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (moved || wallblks || busy || col != 5'd0) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL rst_after got=%0d exp=0", errs); end
    endtask

    initial begin
        reset_n = 1'b0;
        {left, up, down, right} = 4'b0;
        map_we = 1'b0; map_row = '0; map_data = '0;
        test_reset();
        test_move_right();
        test_wall();
        test_invalid();
        test_autorepeat();
        test_win();
        test_reset_lookup();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maze_mover.md
Name: maze_mover

Overview:
- Sequential player-movement controller for the tile maze. Holds a loadable wall bitmap and the player's tile position.
- Validates each single-direction move request against the map and the grid edges through a small FSM with auto-repeat cooldown.
- Drives the player's pixel bounding box to the VGA renderer, with moved/blocked pulses and a sticky win flag.
- Replaces hard-coded wall rectangles with a parametrised, runtime-loadable grid.

Parameters:
- COLS, 20, grid columns.
- ROWS, 16, grid rows.
- TILE_W, 32, tile width in pixels.
- TILE_H, 30, tile height in pixels.
- START_COL, 0, reset column.
- START_ROW, 0, reset row.
- GOAL_COL, 19, goal column.
- GOAL_ROW, 15, goal row.
- HOLD_CYCLES, 4, cooldown cycles after each commit (0 allowed).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- left, up, down, right  input  1 each  debounced direction levels.
- map_we  input  1  map row write enable.
- map_row  input  $clog2(ROWS)  row to write.
- map_data  input  COLS  wall bits; bit c set = wall at column c.
- col  output  $clog2(COLS)  current column.
- row  output  $clog2(ROWS)  current row.
- xFlr, xCeil, yFlr, yCeil  output  10 each  pixel bounds.
- moved  output  1  one-cycle pulse on a successful move.
- wallblks  output  1  one-cycle pulse on a rejected move.
- busy  output  1  FSM not IDLE.
- win  output  1  sticky, set once position equals goal.

Behaviour:
- Reset (async, reset_n=0):
  - col=START_COL, row=START_ROW.
  - Map cleared to all-open.
  - FSM=IDLE; moved=wallblks=win=0; cooldown counter=0.
  - Pixel outputs at reset: xFlr=START_COL*TILE_W, xCeil=xFlr+TILE_W, yFlr=START_ROW*TILE_H, yCeil=yFlr+TILE_H.
- Reset mid-operation aborts any move; no pulse is produced.
- Elaboration constraint: COLS*TILE_W <= 1023 and ROWS*TILE_H <= 1023.
- Pixel outputs are registered and update in the same edge as col/row.
- Valid request: exactly one of left/up/down/right high, sampled in IDLE with win=0. Zero or ≥2 directions high: stay IDLE, no pulse.
- FSM states: IDLE -> LOOKUP -> COMMIT -> COOL -> IDLE.
  - IDLE, edge N: on a valid request, capture the target tile (col±1 or row±1) and an oob flag. oob=1 when the target is outside 0..COLS-1 / 0..ROWS-1; no wrap-around. Go to LOOKUP.
  - LOOKUP, edge N+1: wall_q <= map[target_row][target_col]. If oob, wall_q is don't-care.
  - COMMIT, edge N+2:
    - If oob or wall_q: wallblks=1 for the following cycle, position unchanged.
    - Else: update col/row and pixel bounds, moved=1 for the following cycle.
    - Next state: COOL if HOLD_CYCLES>0, else IDLE.
  - COOL: the counter loads HOLD_CYCLES-1 on entry and decrements each cycle; go to IDLE when it reaches 0. COOL therefore lasts exactly HOLD_CYCLES cycles.
- Auto-repeat: a direction held through COOL is re-sampled in IDLE. Repeat period is 3+HOLD_CYCLES cycles.
- Direction changes after edge N are ignored until the next IDLE.
- busy=1 in LOOKUP, COMMIT and COOL.
- Map writes:
  - Accepted in any state; the row is replaced at the edge.
  - A write to the row being read in the same LOOKUP edge returns old data.
  - Writes never move the player, even onto a wall cell.
- win: set at the edge where the committed position equals (GOAL_COL, GOAL_ROW), or at reset if the start equals the goal. Cleared only by reset. While win=1, IDLE ignores all requests.

Test Plan:
- Reset with defaults -> col=0, row=0, xFlr=0, xCeil=32, yFlr=0, yCeil=30, busy=0, moved=wallblks=win=0.
- Open map, right high for 1 cycle at edge N -> busy from N, at N+2 col=1, xFlr=32, xCeil=64, moved pulse 1 cycle, IDLE again at N+2+HOLD_CYCLES.
- Write map_row=0, map_data bit1=1, then request right from (0,0) -> wallblks pulse at N+2, col stays 0, moved=0. Then left at col 0 -> wallblks pulse (oob).
- left+up together, or no direction, for 10 cycles -> busy stays 0, no pulses, position unchanged.
- Hold down with HOLD_CYCLES=4, open map -> row increments every 7 cycles (0,1,2,3); release mid-COOL -> no further move.
- Walk to (19,15) -> win=1 and stays 1, further requests ignored. Assert reset_n=0 during LOOKUP -> immediate return to (0,0), win=0, no pulse.
